// File: rtl/sig_pipe_ctrl.sv
// sig_pipe_ctrl: turns stream valid/ready handshakes into the global stall for the sigma pipelines.
// Define SIG_PIPE_CTRL_PERF_EN to build the backpressure/starvation stall counters.
module sig_pipe_ctrl #(
   parameter int PIXELS_PER_BEAT = 16,
   parameter int IMAGE_DIM       = 512,
   parameter int PIPE_LATENCY    = 4
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic        start,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        m_ready,
   output logic        m_valid,
   output logic        m_last,
   output logic        stall,
   output logic        flush_sel,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] stall_bp_cnt,
   output logic [31:0] stall_st_cnt
);
   localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
   localparam int CW    = $clog2(BEATS);
   localparam int FW    = $clog2(PIPE_LATENCY);
   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
   state_t                  state, state_nxt;
   logic [PIPE_LATENCY-1:0] vld;
   logic [CW-1:0]           in_cnt, out_cnt;
   logic [FW-1:0]           fl_cnt;
   logic                    taken, out_free, adv, acc, hs, last_in, last_out, last_fl, go, fin;
   always_comb begin
      m_valid   = vld[PIPE_LATENCY-1] & ~taken;
      out_free  = ~vld[PIPE_LATENCY-1] | taken | m_ready;
      adv       = (((state == RUN) & s_valid) | (state == FLUSH)) & out_free;
      stall     = ~adv;
      s_ready   = (state == RUN) & out_free;
      flush_sel = state == FLUSH;
      busy      = state != IDLE;
      acc       = s_valid & s_ready;
      hs        = m_valid & m_ready;
      last_in   = in_cnt == CW'(BEATS - 1);
      last_out  = out_cnt == CW'(BEATS - 1);
      last_fl   = fl_cnt == FW'(PIPE_LATENCY - 2);
      m_last    = m_valid & last_out;
      go        = (state == IDLE) & start;
      fin       = (state == DRAIN) & hs;
      state_nxt = go                                ? RUN   :
                  (state == RUN && acc && last_in)  ? FLUSH :
                  (state == FLUSH && adv && last_fl) ? DRAIN :
                  fin                               ? IDLE  : state;
   end
   // Leaving DRAIN empties the slot array so every frame starts from an all-zero vld.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= IDLE;
         vld     <= '0;
         taken   <= 1'b0;
         in_cnt  <= '0;
         out_cnt <= '0;
         fl_cnt  <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         done    <= fin;
         vld     <= fin ? '0 : adv ? {vld[PIPE_LATENCY-2:0], state == RUN} : vld;
         taken   <= !fin && (adv ? 1'b0 : hs ? 1'b1 : taken);
         in_cnt  <= go ? '0 : acc ? (last_in ? '0 : in_cnt + 1'b1) : in_cnt;
         out_cnt <= go ? '0 : hs ? (last_out ? '0 : out_cnt + 1'b1) : out_cnt;
         fl_cnt  <= (state != FLUSH) ? '0 : adv ? fl_cnt + 1'b1 : fl_cnt;
         err     <= go ? 1'b0 : err | (acc & (s_last ^ last_in));
      end
   end
`ifdef SIG_PIPE_CTRL_PERF_EN
   logic [31:0] bp_cnt, st_cnt;
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         bp_cnt <= '0;
         st_cnt <= '0;
      end else begin
         bp_cnt <= go ? '0 : (state == RUN && s_valid && !out_free && !(&bp_cnt)) ? bp_cnt + 32'd1 : bp_cnt;
         st_cnt <= go ? '0 : (state == RUN && !s_valid && !(&st_cnt)) ? st_cnt + 32'd1 : st_cnt;
      end
   end
   assign stall_bp_cnt = bp_cnt;
   assign stall_st_cnt = st_cnt;
`else
   assign stall_bp_cnt = '0;
   assign stall_st_cnt = '0;
`endif
endmodule

// File: tb/tb_sig_pipe_ctrl.sv
// tb_sig_pipe_ctrl: directed bench for sig_pipe_ctrl with a 16-beat frame (IMAGE_DIM=16, PIPE_LATENCY=4).
module tb_sig_pipe_ctrl;
   logic        clk, aresetn, start, s_valid, s_last, s_ready, m_ready, m_valid, m_last;
   logic        stall, flush_sel, busy, done, err;
   logic [31:0] stall_bp_cnt, stall_st_cnt;
   logic [7:0]  obs, exp8;
   int          n_tests = 0, n_fail = 0, n_in = 0, n_out = 0;
   sig_pipe_ctrl #(.PIXELS_PER_BEAT(16), .IMAGE_DIM(16), .PIPE_LATENCY(4)) dut (
      .clk(clk), .aresetn(aresetn), .start(start), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last), .stall(stall),
      .flush_sel(flush_sel), .busy(busy), .done(done), .err(err),
      .stall_bp_cnt(stall_bp_cnt), .stall_st_cnt(stall_st_cnt)
   );
   assign obs = {stall, s_ready, m_valid, m_last, flush_sel, busy, done, err};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input logic sv, input logic sl, input logic mr);
      s_valid = sv;
      s_last  = sl;
      m_ready = mr;
      #1;
      if (s_valid && s_ready) n_in++;
      if (m_valid && m_ready) n_out++;
   endtask
   task automatic begin_frame();
      s_valid = 1'b0;
      m_ready = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      n_in  = 0;
      n_out = 0;
   endtask
   task automatic drain_frame(input string tag, input int last_idx, input logic exp_err);
      int   g    = 0;
      logic seen = 1'b0;
      while (!seen && g < 200) begin
         set_in(n_in < 16, n_in == last_idx, 1'b1);
         if (m_valid && m_ready) check({tag, " m_last"}, m_last, n_out == 16);
         seen = done;
         if (!seen) tick();
         g++;
      end
      check({tag, " done"}, seen, 1);
      check({tag, " beats in"}, n_in, 16);
      check({tag, " beats out"}, n_out, 16);
      check({tag, " err"}, err, exp_err);
   endtask
   initial begin
      int g;
      aresetn = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      tick();
      tick();
      check("reset outputs", obs, 8'b1000_0000);
      check("reset bp_cnt", stall_bp_cnt, 0);
      check("reset st_cnt", stall_st_cnt, 0);
      aresetn = 1'b1;
      tick();
      // full-rate frame, cycle c counted from the first RUN cycle
      begin_frame();
      for (int c = 1; c <= 21; c++) begin
         set_in(c <= 16, c == 16, 1'b1);
         exp8 = {c >= 20, c <= 16, c >= 5 && c <= 20, c == 20, c >= 17 && c <= 19, c <= 20, c == 21, 1'b0};
         check($sformatf("full c%0d", c), obs, exp8);
         tick();
      end
      check("full beats out", n_out, 16);
      // downstream backpressure right after the first output
      begin_frame();
      for (int c = 1; c <= 5; c++) begin
         set_in(1'b1, 1'b0, 1'b1);
         tick();
      end
      for (int c = 6; c <= 10; c++) begin
         set_in(1'b1, 1'b0, 1'b0);
         check($sformatf("bp c%0d stall/s_ready/m_valid", c), {stall, s_ready, m_valid}, 3'b101);
         tick();
      end
      drain_frame("bp", 15, 1'b0);
`ifdef SIG_PIPE_CTRL_PERF_EN
      check("bp stall_bp_cnt", stall_bp_cnt, 5);
`else
      check("bp stall_bp_cnt", stall_bp_cnt, 0);
`endif
      check("bp stall_st_cnt", stall_st_cnt, 0);
      tick();
      // output taken while upstream is starved; a stray start must be ignored
      begin_frame();
      for (int c = 1; c <= 5; c++) begin
         set_in(1'b1, 1'b0, 1'b1);
         tick();
      end
      set_in(1'b0, 1'b0, 1'b1);
      check("starve c6 stall/m_valid", {stall, m_valid}, 2'b11);
      tick();
      start = 1'b1;
      set_in(1'b0, 1'b0, 1'b0);
      check("starve c7 stall/s_ready/m_valid", {stall, s_ready, m_valid}, 3'b110);
      tick();
      start = 1'b0;
      set_in(1'b0, 1'b0, 1'b1);
      check("starve c8 stall/m_valid", {stall, m_valid}, 2'b10);
      tick();
      set_in(1'b1, 1'b0, 1'b0);
      check("starve c9 stall", stall, 0);
      tick();
      set_in(1'b1, 1'b0, 1'b1);
      check("starve c10 stall/m_valid", {stall, m_valid}, 2'b01);
      tick();
      drain_frame("starve", 15, 1'b0);
`ifdef SIG_PIPE_CTRL_PERF_EN
      check("starve stall_st_cnt", stall_st_cnt, 3);
`else
      check("starve stall_st_cnt", stall_st_cnt, 0);
`endif
      check("starve stall_bp_cnt", stall_bp_cnt, 0);
      tick();
      // early s_last on beat 10
      begin_frame();
      drain_frame("early last", 10, 1'b1);
      tick();
      check("err sticky after done", err, 1);
      begin_frame();
      set_in(1'b0, 1'b0, 1'b1);
      check("err cleared by start", err, 0);
      // reset while flushing
      g = 0;
      set_in(1'b1, 1'b0, 1'b1);
      while (!flush_sel && g < 50) begin
         tick();
         set_in(n_in < 16, n_in == 15, 1'b1);
         g++;
      end
      check("flush reached", flush_sel, 1);
      aresetn = 1'b0;
      #1;
      check("async reset in flush", obs, 8'b1000_0000);
      tick();
      check("reset held", obs, 8'b1000_0000);
      aresetn = 1'b1;
      tick();
      begin_frame();
      drain_frame("after reset", 15, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
